dmem_responder: RTL and testbench
=================================

# dmem_responder

Sequential data-memory responder: the target end of the core's load/store port. It accepts one word-addressed, byte-strobed read or write request over a valid/ready handshake. After a programmable number of wait states it returns a response over a second valid/ready handshake. It replaces the zero-latency combinational data memory when the core is extended to a stalling, handshaked memory interface. It also serves as the reference target for verifying that interface.

## Interface
Parameters:
- DEPTH, 256: number of 32-bit words in storage; valid word indices 0..DEPTH-1.
- LATENCY, 2: wait-state cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, already lane-aligned.
- req_wstrb  in  4  byte enables; bit i enables wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  request faulted.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, WAIT, RESP. A 4-bit countdown counter is used in WAIT.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid&&req_ready, latch we, addr, wdata, wstrb.
  - Go to WAIT with counter=LATENCY-1 if LATENCY>0; otherwise go to RESP.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle.
  - Go to RESP on the edge where counter==0.
- Commit edge (the edge that enters RESP):
  - Compute word index = addr[31:2].
  - err = (addr[1:0]!=0) || (index>=DEPTH).
  - Read, no error: rsp_rdata <= mem[index].
  - Write, no error: for each set wstrb bit, write that byte of mem[index]; rsp_rdata <= 0.
  - Error: no memory change; rsp_rdata <= 0; rsp_err <= 1.
  - Write with wstrb=0: no change, no error.
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On that handshake, go to IDLE and clear rsp_err and rsp_rdata.
- One transaction is outstanding at most. Requests are not accepted while busy.
- Memory contents are not affected by reset. Simulation initialises them to 0.

## Timing
- Reset values (async, immediate): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counter=0.
- Request accepted at the edge ending cycle 0:
  - WAIT occupies cycles 1..LATENCY.
  - rsp_valid goes high in cycle LATENCY+1.
- rsp_ready held high: handshake occurs in cycle LATENCY+1, req_ready returns high in cycle LATENCY+2. Back-to-back period is LATENCY+2 cycles.
- rsp_ready low: RESP is held indefinitely with outputs frozen (backpressure).
- A read issued after a completed write to the same word returns the new data (the write commits before that write's response).
- Reset asserted mid-WAIT: the transaction is dropped and no write occurs. Reset asserted in RESP: the write has already committed and the response is discarded.
- Address wrap: only addr[31:2] is compared against DEPTH. No aliasing; out-of-range requests error.
- req_* inputs are ignored outside IDLE.

## Test plan
- Reset, LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, rsp_ready=1 -> rsp_valid in cycle 3, err=0, rdata=0. Read 0x10 -> rdata 0xDEADBEEF.
- Byte strobes: mem[0x20]=0x11223344, then write wdata 0xAABBCCDD with wstrb 0b0101 -> read 0x20 returns 0x11BB33DD.
- Errors: read 0x13 -> err=1, rdata=0. Read DEPTH*4 -> err=1. Write to 0x14 with err addr 0x15 -> mem[0x14] unchanged.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rdata, err stable and req_ready=0 throughout; handshake in cycle 6 -> req_ready=1 in the next cycle.
- LATENCY=0: accept in cycle 0 -> rsp_valid in cycle 1. Continuous requests with rsp_ready=1 -> one accept every 2 cycles.
- Reset mid-WAIT of write 0x55555555 to 0x8 (prior value 0) -> all outputs at reset values immediately; a later read of 0x8 returns 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Handshaked data-memory target: accepts one byte-strobed word read/write and
// answers after LATENCY wait states, holding the response until it is taken.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, next_state;
    logic [3:0]  count;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_wstrb;
    logic [31:0] mem [DEPTH];

    logic             accept;
    logic             commit;
    logic             c_we;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [3:0]       c_wstrb;
    logic             c_err;
    logic [IDX_W-1:0] c_idx;

    assign accept = req_valid && (state == IDLE);
    assign commit = ((state == WAIT) && (count == 4'd0)) || (accept && (LATENCY == 0));

    // With zero wait states the commit edge is the accept edge, so the live
    // request is used instead of the not-yet-latched copy.
    always_comb begin
        c_we    = lat_we;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        c_wstrb = lat_wstrb;
        if (state == IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
        end
        c_err = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH));
        c_idx = c_addr[IDX_W+1:2];
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (accept) next_state = (LATENCY == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (count == 4'd0) next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_wstrb <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
                count     <= WAIT_LOAD;
            end else if ((state == WAIT) && (count != 4'd0)) begin
                count <= count - 4'd1;
            end
            if (commit) begin
                rsp_err   <= c_err;
                rsp_rdata <= (!c_err && !c_we) ? mem[c_idx] : 32'd0;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

    // NOTE: storage is deliberately not reset; contents survive rst like a real RAM.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            for (int b = 0; b < 4; b++) begin
                if (c_wstrb[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of transactions with a response scoreboard,
// plus backpressure, back-to-back and reset-in-WAIT sequences for LATENCY 2 and 0.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_ready;

    logic        rr2, rv2, re2, bz2, rr0, rv0, re0, bz0;
    logic [31:0] rd2, rd0;
    logic        m_req_ready, m_rsp_valid, m_rsp_err, m_busy;
    logic [31:0] m_rsp_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && !sel), .req_ready(rr2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rv2), .rsp_ready(rsp_ready && !sel),
        .rsp_rdata(rd2), .rsp_err(re2), .busy(bz2)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid && sel), .req_ready(rr0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rv0), .rsp_ready(rsp_ready && sel),
        .rsp_rdata(rd0), .rsp_err(re0), .busy(bz0)
    );

    assign m_req_ready = sel ? rr0 : rr2;
    assign m_rsp_valid = sel ? rv0 : rv2;
    assign m_rsp_rdata = sel ? rd0 : rd2;
    assign m_rsp_err   = sel ? re0 : re2;
    assign m_busy      = sel ? bz0 : bz2;

    typedef struct {
        logic        sel;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    localparam int NV = 19;
    vec_t vecs [NV];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the response handshake.
    task automatic do_txn(input vec_t v, input string name);
        exp_t e;
        int   cyc;
        sel       = v.sel;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        for (int n = 0; n < 20 && !m_req_ready; n++) @(negedge clk);
        check({name, " req_ready"}, 32'(m_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!m_rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 32'(cyc), v.sel ? 32'd1 : 32'd3);
        if (sb.size() == 0) begin
            check({name, " scoreboard"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({name, " rdata"}, m_rsp_rdata, e.rdata);
            check({name, " err"}, 32'(m_rsp_err), 32'(e.err));
        end
        @(negedge clk);
        check({name, " ready after"}, 32'(m_req_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " req_ready"}, 32'(m_req_ready), 32'd1);
        check({name, " rsp_valid"}, 32'(m_rsp_valid), 32'd0);
        check({name, " rdata"}, m_rsp_rdata, 32'd0);
        check({name, " err"}, 32'(m_rsp_err), 32'd0);
        check({name, " busy"}, 32'(m_busy), 32'd0);
    endtask

    initial begin
        int cnt;
        vecs[0]  = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h20, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h13, 32'h0,        4'h0, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h400, 32'h0,       4'h0, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h14, 32'h12345678, 4'hF, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h15, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 32'h14, 32'h0,        4'h0, 32'h12345678, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h18, 32'h0BADC0DE, 4'hF, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h18, 32'hCAFEF00D, 4'h0, 32'h0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h18, 32'h0,        4'h0, 32'h0BADC0DE, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h3FC, 32'h01020304, 4'hF, 32'h0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h3FC, 32'h0,       4'h0, 32'h01020304, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 32'h80000010, 32'h0,  4'h0, 32'h0, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 32'h40, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 32'h41, 32'h0,        4'h0, 32'h0, 1'b1};

        rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_wstrb = 4'd0; rsp_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: response held five cycles while a stray request is ignored.
        sel = 1'b0; req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_wdata = 32'h0; req_wstrb = 4'hF;
        check("bp busy", 32'(m_busy), 32'd1);
        cnt = 1;
        while (!m_rsp_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp rsp_valid", 32'(m_rsp_valid), 32'd1);
            check("bp rdata", m_rsp_rdata, 32'hDEADBEEF);
            check("bp err", 32'(m_rsp_err), 32'd0);
            check("bp req_ready", 32'(m_req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("bp cycle6 valid", 32'(m_rsp_valid), 32'd1);
        @(negedge clk);
        check("bp release ready", 32'(m_req_ready), 32'd1);
        check("bp release valid", 32'(m_rsp_valid), 32'd0);
        check("bp release rdata", m_rsp_rdata, 32'd0);
        do_txn('{1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0}, "bp ignored write");

        // Back-to-back period is LATENCY+2 cycles.
        sel = 1'b0; req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1; rsp_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_req_ready) cnt++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b lat2 accepts", 32'(cnt), 32'd2);
        @(negedge clk);
        sel = 1'b1; req_addr = 32'h40; req_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_req_ready) cnt++;
            if (m_rsp_valid) check("b2b lat0 rdata", m_rsp_rdata, 32'hA5A5A5A5);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("b2b lat0 accepts", 32'(cnt), 32'd5);
        @(negedge clk);

        // Reset in WAIT drops the write.
        do_txn('{1'b0, 1'b1, 32'h8, 32'h0, 4'hF, 32'h0, 1'b0}, "clr 0x8");
        sel = 1'b0; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'h55555555;
        req_wstrb = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midwait busy", 32'(m_busy), 32'd1);
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        check_reset_outputs("midwait reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_txn('{1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0}, "after reset 0x8");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
